// File: rtl/dh_responder.sv
// Diffie-Hellman responder: B = G^X mod P and KEY = A^X mod P via lockstep square-and-multiply.
// Optional DH_RESP_ZEROIZE_EN wipes key material (B, KEY, X, RG, RA) once the result is consumed.
module dh_responder #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] G,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] X,
  input  logic             A_VALID,
  output logic             A_READY,
  input  logic [WIDTH-1:0] A,
  output logic             B_VALID,
  input  logic             B_READY,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] KEY,
  output logic             ERR,
  output logic             BUSY
);

  typedef enum logic [1:0] {IDLE, EXP, DONE} state_t;

  localparam int              SW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [SW-1:0]   LAST = SW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] g_q, p_q, x_q, a_q;
  logic [WIDTH-1:0] rg, ra, tg, ta;
  logic [WIDTH-1:0] b_q, key_q;
  logic             err_q;
  logic [SW-1:0]    step, bit_idx, mul_idx;
  logic             phase_mul;

  logic             op_ok, last_step, exp_last, commit;
  logic             mbit_g, mbit_a, a_fire, b_fire;
  logic [WIDTH-1:0] tg_in, ta_in, ng, na, rg_commit, ra_commit;

  // One interleaved shift-add step: T = 2T mod M, then optionally T = T + mcand mod M.
  // Inputs are residues below M, so one conditional subtract per stage is enough.
  function automatic logic [WIDTH-1:0] mod_step(input logic [WIDTH-1:0] t,
                                                input logic [WIDTH-1:0] mcand,
                                                input logic             mbit,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = {t, 1'b0};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    if (mbit) begin
      s = s + {1'b0, mcand};
      if (s >= {1'b0, m}) s = s - {1'b0, m};
    end
    return s[WIDTH-1:0];
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    op_ok     = (p_q >= WIDTH'(2)) && (g_q < p_q) && (a_q < p_q);
    last_step = (step == LAST);
    exp_last  = last_step && phase_mul && (bit_idx == '0);
    mul_idx   = LAST - step;
    mbit_g    = phase_mul ? g_q[mul_idx] : rg[mul_idx];
    mbit_a    = phase_mul ? a_q[mul_idx] : ra[mul_idx];
    tg_in     = (step == '0) ? '0 : tg;
    ta_in     = (step == '0) ? '0 : ta;
    ng        = mod_step(tg_in, rg, mbit_g, p_q);
    na        = mod_step(ta_in, ra, mbit_a, p_q);
    // MUL phase always runs for constant timing; the product only lands when the exponent bit is set.
    commit    = !phase_mul || x_q[bit_idx];
    rg_commit = commit ? ng : rg;
    ra_commit = commit ? na : ra;
  end

  always_comb begin
    state_nxt = state;
    A_READY   = 1'b0;
    B_VALID   = 1'b0;
    BUSY      = 1'b1;
    case (state)
      IDLE: begin
        A_READY = 1'b1;
        BUSY    = 1'b0;
        if (A_VALID) state_nxt = EXP;
      end
      EXP:     if (!op_ok || exp_last) state_nxt = DONE;
      DONE: begin
        B_VALID = 1'b1;
        if (B_READY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign a_fire = A_VALID && A_READY;
  assign b_fire = B_VALID && B_READY;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      g_q       <= '0;
      p_q       <= '0;
      x_q       <= '0;
      a_q       <= '0;
      rg        <= '0;
      ra        <= '0;
      tg        <= '0;
      ta        <= '0;
      b_q       <= '0;
      key_q     <= '0;
      err_q     <= 1'b0;
      step      <= '0;
      bit_idx   <= '0;
      phase_mul <= 1'b0;
    end else if (a_fire) begin
      g_q       <= G;
      p_q       <= P;
      x_q       <= X;
      a_q       <= A;
      rg        <= WIDTH'(1);
      ra        <= WIDTH'(1);
      step      <= '0;
      bit_idx   <= LAST;
      phase_mul <= 1'b0;
    end else if (state == EXP) begin
      // Operand check sits on the captured copies, so a reject costs exactly one EXP cycle.
      if (!op_ok) begin
        err_q <= 1'b1;
        b_q   <= '0;
        key_q <= '0;
      end else begin
        step <= last_step ? '0 : step + 1'b1;
        tg   <= ng;
        ta   <= na;
        if (last_step) begin
          rg        <= rg_commit;
          ra        <= ra_commit;
          phase_mul <= !phase_mul;
          if (phase_mul) bit_idx <= bit_idx - 1'b1;
          if (exp_last) begin
            b_q   <= rg_commit;
            key_q <= ra_commit;
          end
        end
      end
    end else if (b_fire) begin
      err_q <= 1'b0;
`ifdef DH_RESP_ZEROIZE_EN
      b_q   <= '0;
      key_q <= '0;
      x_q   <= '0;
      rg    <= '0;
      ra    <= '0;
`endif
    end
  end

  assign B   = b_q;
  assign KEY = key_q;
  assign ERR = err_q;

endmodule

// File: doc/dh_responder.md
# dh_responder

Responder end of the Diffie-Hellman key exchange. It accepts the initiator's public value A through a valid/ready handshake and computes two results with one shared exponent X: its own public value B = G^X mod P and the shared key KEY = A^X mod P. It returns both results through a second valid/ready handshake. It sits opposite the existing initiator top-level and uses the same G/P/X operand conventions, so the two ends can be cross-checked in one bench.

## Interface
- WIDTH, default 32: operand width of G, P, X, A, B and KEY.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- G  in  WIDTH  generator; sampled at the A handshake.
- P  in  WIDTH  modulus; sampled at the A handshake.
- X  in  WIDTH  responder private exponent; sampled at the A handshake.
- A_VALID  in  1  initiator public value is presented.
- A_READY  out  1  high only in IDLE; it is decoded from the registered state.
- A  in  WIDTH  initiator public value.
- B_VALID  out  1  B, KEY and ERR are valid.
- B_READY  in  1  consumer accepts the result.
- B  out  WIDTH  responder public value G^X mod P.
- KEY  out  WIDTH  shared secret A^X mod P.
- ERR  out  1  operands were rejected.
- BUSY  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, EXP, DONE.
- IDLE:
  - A_READY = 1.
  - When A_VALID && A_READY at a rising edge, register G, P, X and A.
  - Operands are valid when P >= 2, G < P and A < P. All comparisons are unsigned.
  - Invalid operands: go to DONE with ERR = 1, B = 0, KEY = 0.
  - Valid operands: go to EXP with RG = 1, RA = 1, and bit index = WIDTH-1.
- EXP: left-to-right square-and-multiply over all WIDTH exponent bits, including leading zeros. Run time is therefore data-independent.
  - Per exponent bit, a SQR phase of WIDTH cycles (R = R·R mod P) is followed by a MUL phase of WIDTH cycles.
  - In the MUL phase, RG = RG·G mod P and RA = RA·A mod P. The product is committed only if X[bit] = 1; the phase always runs.
  - Modular multiply is interleaved shift-add, one multiplier bit per cycle, MSB first:
    - T = 2T, then subtract P if T >= P.
    - If the multiplier bit is 1: T = T + multiplicand, then subtract P if T >= P.
  - Intermediate values are WIDTH+1 bits wide. Every stored residue stays in [0, P-1].
  - The RG and RA datapaths run in lockstep from one sequencer.
- DONE:
  - B = RG, KEY = RA, B_VALID = 1.
  - Outputs hold stable while B_READY = 0.
  - On B_VALID && B_READY, go to IDLE and clear ERR.
- A_VALID is ignored outside IDLE; there is no queuing.

## Timing
- Reset values: state IDLE, A_READY = 1, B_VALID = 0, B = 0, KEY = 0, ERR = 0, BUSY = 0. All internal registers are cleared.
- Valid transaction: the handshake is at edge 0. B_VALID rises after edge 2·WIDTH·WIDTH, which is 2048 cycles for WIDTH = 32.
- Rejected transaction: B_VALID rises after edge 1.
- After the B handshake edge, A_READY is high in the next cycle. Minimum spacing between two A handshakes is latency + 1.
- Reset asserted in any state, including mid-EXP: immediately return to reset values. A_READY is 1 once the state is IDLE. The partial computation is discarded.
- X = 0 gives B = 1 and KEY = 1 with full latency.
- G = 0 or A = 0 is valid (result 0 for X != 0).

## Configuration
- DH_RESP_ZEROIZE_EN defined:
  - On the B handshake edge, clear B, KEY, the captured X, RG and RA to 0.
  - On reset, clear the same registers.
  - Key material does not persist after consumption.
- Macro not defined: B and KEY retain their last values in IDLE until the next DONE. Only reset clears them.

## Test plan
- Basic values, WIDTH = 32: G=5, P=23, X=6, A=8, B_READY=1 -> B_VALID after 2048 cycles, B=8, KEY=13, ERR=0.
- Zero exponent: G=5, P=23, X=0, A=8 -> B=1, KEY=1, full 2048-cycle latency.
- Wide operands: P=0xFFFFFFFB, G=2, X=2, A=0xFFFFFFFA -> B=4, KEY=1.
- Operand check: P=23, A=23 -> ERR=1, B=0, KEY=0, B_VALID after 1 cycle. Repeat with P=1 -> same response.
- Backpressure and ignored input: hold B_READY=0 for 10 cycles after B_VALID while toggling A_VALID -> B, KEY and ERR stable, A_READY=0, BUSY=1. Raise B_READY -> IDLE on the next cycle.
- Reset mid-operation: drop RST at cycle 1000 of EXP -> all outputs at reset values, A_READY=1. Rerun the basic-values case -> B=8, KEY=13. With DH_RESP_ZEROIZE_EN, B and KEY read 0 in IDLE after the handshake.
